// File: rtl/pipelined_negator.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_negator
// Description : Multi-cycle two's-complement negate / absolute-value unit.
//               Processes CHUNK bits per clock, least-significant chunk
//               first, rippling the +1 carry through a register. Valid/ready
//               handshake on both sides; zero and overflow flags on output.
//               Optional macro NEGATOR_SATURATE_EN clamps the most-negative
//               negation to the most-positive value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_negator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Most-negative value: the only input whose negation does not fit.
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef NEGATOR_SATURATE_EN
   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] src_q,   src_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic             neg_q,   neg_d;
   logic             carry_q, carry_d;
   logic [KW-1:0]    k_q,     k_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             zero_q,  zero_d;
   logic             ovf_q,   ovf_d;

   int               w_base;
   logic [CHUNK-1:0] w_src_chunk;
   logic [CHUNK-1:0] w_res_chunk;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_ovf;
   logic [WIDTH-1:0] w_final;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = data_q;
   assign out_zero  = zero_q;
   assign out_ovf   = ovf_q;

   // Chunk datapath, FSM transitions and result capture at the last chunk.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      k_d     = k_q;
      data_d  = data_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;

      w_base      = int'(k_q) * CHUNK;
      w_src_chunk = src_q[w_base +: CHUNK];
      // Negation is ~x + 1; the +1 arrives as the rippled carry.
      w_res_chunk = neg_q ? (~w_src_chunk + {{(CHUNK-1){1'b0}}, carry_q})
                          : w_src_chunk;
      w_acc_next  = acc_q;
      w_acc_next[w_base +: CHUNK] = w_res_chunk;

      w_ovf = neg_q & (src_q == MIN_VAL);
`ifdef NEGATOR_SATURATE_EN
      w_final = w_ovf ? MAX_VAL : w_acc_next;
`else
      w_final = w_acc_next;
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               src_d   = in_data;
               neg_d   = ~mode | in_data[WIDTH-1];
               carry_d = 1'b1;
               k_d     = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d   = w_acc_next;
            // Carry survives a chunk only if every inverted bit was 1.
            carry_d = carry_q & (w_src_chunk == '0);
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) begin
               k_d     = '0;
               data_d  = w_final;
               zero_d  = (w_final == '0);
               ovf_d   = w_ovf;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; asynchronous reset discards any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         k_q     <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
`default_nettype wire
